// File: rtl/secuenciador_barrido.sv
// secuenciador_barrido: applies the 8 input vectors {A,B,C} to a 3-input logic block,
// waits for it to settle and counts the vectors whose 6 outputs differ from GOLDEN.
module secuenciador_barrido #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [47:0] GOLDEN        = 48'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inicio,
    input  logic [5:0] s_in,
    output logic [2:0] abc,
    output logic       ocupado,
    output logic       listo,
    output logic       aprobado,
    output logic [3:0] errores,
    output logic [2:0] primer_fallo,
    output logic       fallo_valido
);
    typedef enum logic [2:0] {IDLE, APLICAR, ESPERA, CAPTURA, FIN} state_t;
    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
    state_t     state, state_n;
    logic [2:0] idx, idx_n, primer_fallo_n;
    logic [3:0] cnt, cnt_n, errores_n;
    logic       fallo_valido_n, aprobado_n, mismatch;
    assign mismatch = s_in != GOLDEN[6*idx +: 6];
    assign ocupado  = state != IDLE;
    assign listo    = state == FIN;
    always_comb begin
        state_n        = state;
        idx_n          = idx;
        cnt_n          = cnt;
        errores_n      = errores;
        primer_fallo_n = primer_fallo;
        fallo_valido_n = fallo_valido;
        aprobado_n     = aprobado;
        case (state)
            IDLE: if (inicio) begin
                state_n        = APLICAR;
                idx_n          = 3'd0;
                errores_n      = 4'd0;
                primer_fallo_n = 3'd0;
                fallo_valido_n = 1'b0;
                aprobado_n     = 1'b0;
            end
            APLICAR: begin
                state_n = SETTLE == 4'd0 ? CAPTURA : ESPERA;
                cnt_n   = SETTLE;
            end
            ESPERA: begin
                cnt_n   = cnt - 4'd1;
                state_n = cnt <= 4'd1 ? CAPTURA : ESPERA;
            end
            CAPTURA: begin
                errores_n = mismatch ? errores + 4'd1 : errores;
                if (mismatch && !fallo_valido) begin
                    primer_fallo_n = idx;
                    fallo_valido_n = 1'b1;
                end
                // the last vector's own mismatch must already count towards aprobado
                state_n    = idx == 3'd7 ? FIN : APLICAR;
                idx_n      = idx == 3'd7 ? idx : idx + 3'd1;
                aprobado_n = idx == 3'd7 ? errores_n == 4'd0 : aprobado;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= 3'd0;
            cnt          <= 4'd0;
            abc          <= 3'd0;
            errores      <= 4'd0;
            primer_fallo <= 3'd0;
            fallo_valido <= 1'b0;
            aprobado     <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            cnt          <= cnt_n;
            abc          <= state_n == IDLE ? 3'd0 : idx_n;
            errores      <= errores_n;
            primer_fallo <= primer_fallo_n;
            fallo_valido <= fallo_valido_n;
            aprobado     <= aprobado_n;
        end
    end
endmodule

// File: tb/tb_secuenciador_barrido.sv
// tb_secuenciador_barrido: two sequencers (settle 2 with a real logic block, settle 0 against
// an all-ones golden) checked every cycle against a sweep-position model, plus pinned literals.
module tb_secuenciador_barrido;
    function automatic logic [5:0] lut(input logic [2:0] v);
        logic a, b, c;
        {a, b, c} = v;
        return {(a & b) | (b & c) | (a & c), (a & ~b) | c, ~(b & c), a ^ b ^ c, a | c, a & b};
    endfunction
    function automatic logic [47:0] gold();
        logic [47:0] g;
        for (int k = 0; k < 8; k++) g[6*k +: 6] = lut(3'(k));
        return g;
    endfunction
    localparam logic [47:0] G0 = gold();
    localparam logic [47:0] G1 = 48'hFFFF_FFFF_FFFF;

    logic clk = 0, rst = 1;
    logic ini[2];
    logic [5:0] sin0, sin1;
    logic [5:0] flip[8];
    logic [2:0] abc[2], pf[2];
    logic [3:0] err[2];
    logic ocu[2], lis[2], apr[2], fv[2];
    int vectors = 0, misses = 0;

    always #5 clk = ~clk;
    assign sin0 = lut(abc[0]) ^ flip[abc[0]];

    secuenciador_barrido #(.SETTLE_CYCLES(2), .GOLDEN(G0)) u0 (
        .clk(clk), .rst(rst), .inicio(ini[0]), .s_in(sin0), .abc(abc[0]), .ocupado(ocu[0]),
        .listo(lis[0]), .aprobado(apr[0]), .errores(err[0]), .primer_fallo(pf[0]), .fallo_valido(fv[0]));
    secuenciador_barrido #(.SETTLE_CYCLES(0), .GOLDEN(G1)) u1 (
        .clk(clk), .rst(rst), .inicio(ini[1]), .s_in(sin1), .abc(abc[1]), .ocupado(ocu[1]),
        .listo(lis[1]), .aprobado(apr[1]), .errores(err[1]), .primer_fallo(pf[1]), .fallo_valido(fv[1]));

    // model: k = cycle number within the sweep (1 after the accepting edge), 0 when idle
    int k[2];
    logic [3:0] m_err[2];
    logic [2:0] m_pf[2];
    logic m_fv[2], m_ap[2];
    always @(posedge clk or posedge rst) begin
        int p, v;
        logic [3:0] e;
        logic [5:0] sv;
        logic [47:0] gv;
        logic mm;
        for (int i = 0; i < 2; i++) begin
            p  = i == 0 ? 4 : 2;
            sv = i == 0 ? sin0 : sin1;
            gv = i == 0 ? G0 : G1;
            if (rst) begin
                k[i] <= 0; m_err[i] <= 0; m_pf[i] <= 0; m_fv[i] <= 0; m_ap[i] <= 0;
            end else if (k[i] == 0) begin
                if (ini[i]) begin
                    k[i] <= 1; m_err[i] <= 0; m_pf[i] <= 0; m_fv[i] <= 0; m_ap[i] <= 0;
                end
            end else if (k[i] == 8 * p + 1) begin
                k[i] <= 0;
            end else begin
                k[i] <= k[i] + 1;
                if (k[i] % p == 0) begin
                    v  = k[i] / p - 1;
                    mm = sv != gv[6*v +: 6];
                    e  = m_err[i] + (mm ? 4'd1 : 4'd0);
                    m_err[i] <= e;
                    if (mm && !m_fv[i]) begin
                        m_pf[i] <= 3'(v);
                        m_fv[i] <= 1'b1;
                    end
                    if (v == 7) m_ap[i] <= e == 4'd0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            misses++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic sweep(input int i, input int extra, output int lat);
        int n;
        @(negedge clk);
        ini[i] = 1;
        @(negedge clk);
        ini[i] = 0;
        n = 1;
        while (!lis[i] && n < 300) begin
            @(negedge clk);
            n++;
            ini[i] = n == extra;
        end
        ini[i] = 0;
        if (!lis[i]) chk("listo_timeout", 0, 1);
        lat = n;
    endtask

    initial begin
        int lat, cnt, j, n;
        int tl[3];
        ini[0] = 0; ini[1] = 0; sin1 = 0;
        for (int v = 0; v < 8; v++) flip[v] = 0;
        fork
            begin
                logic [13:0] g, e;
                int p, kk;
                forever begin
                    @(negedge clk);
                    for (int i = 0; i < 2; i++) begin
                        p  = i == 0 ? 4 : 2;
                        kk = k[i];
                        e = {kk == 0 ? 3'd0 : kk == 8 * p + 1 ? 3'd7 : 3'((kk - 1) / p),
                             kk != 0, kk == 8 * p + 1, m_ap[i], m_err[i], m_pf[i], m_fv[i]};
                        g = {abc[i], ocu[i], lis[i], apr[i], err[i], pf[i], fv[i]};
                        vectors++;
                        if (g !== e) begin
                            misses++;
                            $display("FAIL cycle u%0d t=%0t: got abc=%0d ocupado=%b listo=%b aprobado=%b errores=%0d primer_fallo=%0d fallo_valido=%b, expected abc=%0d ocupado=%b listo=%b aprobado=%b errores=%0d primer_fallo=%0d fallo_valido=%b",
                                     i, $time, g[13:11], g[10], g[9], g[8], g[7:4], g[3:1], g[0],
                                     e[13:11], e[10], e[9], e[8], e[7:4], e[3:1], e[0]);
                        end
                    end
                end
            end
        join_none
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({abc[0], ocu[0], lis[0], apr[0], err[0], pf[0], fv[0]}), 0);
        rst = 0;
        // clean sweep
        sweep(0, 0, lat);
        chk("clean_latency", lat, 33);
        chk("clean_aprobado", int'(apr[0]), 1);
        chk("clean_errores", int'(err[0]), 0);
        chk("clean_fallo_valido", int'(fv[0]), 0);
        // S3 flipped only on vector 3
        flip[3] = 6'b000100;
        sweep(0, 0, lat);
        chk("one_fault_errores", int'(err[0]), 1);
        chk("one_fault_primer", int'(pf[0]), 3);
        chk("one_fault_valido", int'(fv[0]), 1);
        chk("one_fault_aprobado", int'(apr[0]), 0);
        flip[3] = 0;
        // settle 0, all-ones golden, s_in=0, stray inicio at cycle 5
        sweep(1, 5, lat);
        chk("s0_latency", lat, 17);
        chk("s0_errores", int'(err[1]), 8);
        chk("s0_primer", int'(pf[1]), 0);
        chk("s0_aprobado", int'(apr[1]), 0);
        cnt = 0;
        repeat (20) begin @(negedge clk); cnt += int'(lis[1]); end
        chk("s0_single_listo", cnt, 0);
        // reset in the middle of a faulty sweep
        flip[1] = 6'h01;
        @(negedge clk); ini[0] = 1;
        @(negedge clk); ini[0] = 0;
        repeat (9) @(negedge clk);
        chk("partial_errores", int'(err[0]), 1);
        #2 rst = 1;
        #1 chk("async_reset", int'({abc[0], ocu[0], lis[0], apr[0], err[0], pf[0], fv[0]}), 0);
        @(negedge clk); rst = 0;
        flip[1] = 0;
        sweep(0, 0, lat);
        chk("after_reset_latency", lat, 33);
        chk("after_reset_aprobado", int'(apr[0]), 1);
        // inicio held high: back-to-back sweeps
        flip[5] = 6'h20;
        @(negedge clk); ini[0] = 1;
        j = 0; n = 0;
        while (j < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (lis[0]) begin
                tl[j] = n;
                chk("held_errores", int'(err[0]), 1);
                j++;
            end
        end
        ini[0] = 0;
        flip[5] = 0;
        chk("held_count", j, 3);
        if (j == 3) begin
            chk("held_first", tl[0], 33);
            chk("held_gap1", tl[1] - tl[0], 34);
            chk("held_gap2", tl[2] - tl[1], 34);
        end
        // randomized sweeps with stray inicio pulses
        for (int r = 0; r < 12; r++) begin
            for (int v = 0; v < 8; v++) flip[v] = $urandom_range(0, 3) == 0 ? 6'($urandom_range(1, 63)) : 6'h0;
            sweep(0, $urandom_range(2, 30), lat);
            chk("rand_latency0", lat, 33);
            sin1 = $urandom_range(0, 2) == 0 ? 6'h3F : 6'($urandom);
            sweep(1, $urandom_range(2, 15), lat);
            chk("rand_latency1", lat, 17);
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
